switch_ctrl_seq: RTL

SWITCH_CTRL_SEQ -- requirements
Module: switch_ctrl_seq

---
 rtl/crossbar_pkg.sv | 13 +
 rtl/switch_ctrl_seq_if.sv | 32 +++
 rtl/switch_cfg_table.sv | 28 ++
 rtl/switch_ctrl_seq.sv | 86 ++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared defaults and FSM state type for the switch control sequencer
package crossbar_pkg;

  localparam int N_SW_DEF  = 4;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/switch_ctrl_seq_if.sv
// rtl/switch_ctrl_seq_if.sv - configuration, playback control and switch-control output bundle
interface switch_ctrl_seq_if
  import crossbar_pkg::*;
#(
  parameter int N_SW  = N_SW_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [N_SW-1:0] cfg_data;
  logic [AW-1:0]   len;
  logic            loop;
  logic            start;
  logic            stop;
  logic [N_SW-1:0] ctr_out;
  logic            ctr_valid;
  logic            busy;
  logic            done;
  logic [AW-1:0]   idx;

  modport master (
    output cfg_we, cfg_addr, cfg_data, len, loop, start, stop,
    input  ctr_out, ctr_valid, busy, done, idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, len, loop, start, stop,
    output ctr_out, ctr_valid, busy, done, idx
  );
endinterface

// File: rtl/switch_cfg_table.sv
// rtl/switch_cfg_table.sv - DEPTH x N_SW register file, one sync write port, one comb read port
module switch_cfg_table
  import crossbar_pkg::*;
#(
  parameter int N_SW  = N_SW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [N_SW-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [N_SW-1:0] rdata_o
);
  logic [N_SW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/switch_ctrl_seq.sv
// rtl/switch_ctrl_seq.sv - plays table entries 0..len onto the switch ctr lines, once or looping
module switch_ctrl_seq
  import crossbar_pkg::*;
#(
  parameter int N_SW  = N_SW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_ctrl_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  state_e          state_q;
  logic [AW-1:0]   idx_q, len_q, rd_addr;
  logic            loop_q, valid_q, busy_q, done_q;
  logic [N_SW-1:0] ctr_q, rd_data, next_entry;
  logic            tbl_we, last;

  assign tbl_we  = bus.cfg_we && (state_q != RUN);
  assign last    = (idx_q == len_q);
  // Read address is the entry to present next: idx+1, or 0 when starting or wrapping.
  assign rd_addr = (state_q == RUN && !last) ? idx_q + AW'(1) : '0;
  // A write landing on the same edge as the read is forwarded so it is never missed.
  assign next_entry = (tbl_we && bus.cfg_addr == rd_addr) ? bus.cfg_data : rd_data;

  switch_cfg_table #(.N_SW(N_SW), .DEPTH(DEPTH), .AW(AW)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (tbl_we),
    .waddr_i (bus.cfg_addr),
    .wdata_i (bus.cfg_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      ctr_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_q <= RUN;
            len_q   <= bus.len;
            loop_q  <= bus.loop;
            idx_q   <= '0;
            ctr_q   <= next_entry;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          // stop outranks both wrap and normal completion
          if (bus.stop || (last && !loop_q)) begin
            state_q <= bus.stop ? IDLE : DONE;
            done_q  <= !bus.stop;
            idx_q   <= '0;
            ctr_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= rd_addr;
            ctr_q <= next_entry;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ctr_out   = ctr_q;
  assign bus.ctr_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.idx       = idx_q;
endmodule
